// File: rtl/muldiv_pkg.sv
// Shared types for the HI/LO multiply/divide unit.
// Op codes, FSM states and the divide-by-zero quotient pattern.
package muldiv_pkg;

  typedef enum logic [3:0] {
    OP_MTHI  = 4'd0,
    OP_MTLO  = 4'd1,
    OP_MULT  = 4'd2,
    OP_MULTU = 4'd3,
    OP_DIV   = 4'd4,
    OP_DIVU  = 4'd5,
    OP_MADD  = 4'd6,
    OP_MADDU = 4'd7,
    OP_MSUB  = 4'd8,
    OP_MSUBU = 4'd9
  } muldiv_op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_ACC,
    S_DIV
  } muldiv_state_t;

  localparam logic [63:0] DIV_ZERO_LO = '1;

endpackage

// File: rtl/muldiv_div_iter.sv
// Iterative restoring radix-2 unsigned divider.
// One quotient bit per cycle; done pulses after WIDTH iterations.
module muldiv_div_iter
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvs;
  logic [CW-1:0]    cnt;
  logic             run;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             ge;

  // Subtraction in WIDTH bits is exact whenever ge holds.
  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    ge      = shifted >= {1'b0, dvs};
    diff    = shifted[WIDTH-1:0] - dvs;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      quo  <= '0;
      rem  <= '0;
      dvs  <= '0;
      cnt  <= '0;
      run  <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        quo <= dividend;
        rem <= '0;
        dvs <= divisor;
        cnt <= '0;
        run <= 1'b1;
      end else if (run) begin
        quo <= {quo[WIDTH-2:0], ge};
        rem <= ge ? diff : shifted[WIDTH-1:0];
        cnt <= cnt + 1'b1;
        if (cnt == CW'(WIDTH - 1)) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign quotient  = quo;
  assign remainder = rem;

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle HI/LO multiply/divide unit with start/busy/done handshake.
// Define MULDIV_MADD_EN to enable MADD/MADDU/MSUB/MSUBU accumulation.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  muldiv_op_t       op,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(MUL_CYCLES + 1);

  muldiv_state_t    state, state_nx;
  logic [CW-1:0]    count;
  logic             accept;
  logic             op_mul, op_div, op_sgn, op_acc, op_sub;
  logic             acc_r, sub_r;
  logic             neg_q, neg_r, div_zero;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH-1:0] q, r;
  logic             div_done;
  logic signed [WIDTH:0]     m_a, m_b;
  logic [2*WIDTH-1:0]        prod;
  logic [2*WIDTH-1:0]        pipe [MUL_CYCLES];

  assign accept = start && (state == S_IDLE);
  assign busy   = (state != S_IDLE);

  always_comb begin
    op_mul = 1'b0;
    op_div = 1'b0;
    op_sgn = 1'b0;
    op_acc = 1'b0;
    op_sub = 1'b0;
    unique case (op)
      OP_MULT:  begin op_mul = 1'b1; op_sgn = 1'b1; end
      OP_MULTU: op_mul = 1'b1;
      OP_DIV:   begin op_div = 1'b1; op_sgn = 1'b1; end
      OP_DIVU:  op_div = 1'b1;
`ifdef MULDIV_MADD_EN
      OP_MADD:  begin op_mul = 1'b1; op_sgn = 1'b1; op_acc = 1'b1; end
      OP_MADDU: begin op_mul = 1'b1; op_acc = 1'b1; end
      OP_MSUB:  begin
        op_mul = 1'b1; op_sgn = 1'b1; op_acc = 1'b1; op_sub = 1'b1;
      end
      OP_MSUBU: begin op_mul = 1'b1; op_acc = 1'b1; op_sub = 1'b1; end
`endif
      default: ;
    endcase
  end

  // Operands are extended by one bit so one signed multiply covers both forms.
  always_comb begin
    m_a   = {op_sgn & in_1[WIDTH-1], in_1};
    m_b   = {op_sgn & in_2[WIDTH-1], in_2};
    prod  = (2*WIDTH)'(m_a * m_b);
    abs_a = (op_sgn && in_1[WIDTH-1]) ? -in_1 : in_1;
    abs_b = (op_sgn && in_2[WIDTH-1]) ? -in_2 : in_2;
  end

  always_ff @(posedge clk) begin
    if (accept && op_mul) pipe[0] <= prod;
    for (int i = 1; i < MUL_CYCLES; i++) pipe[i] <= pipe[i-1];
  end

  muldiv_div_iter #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (accept && op_div),
    .dividend  (abs_a),
    .divisor   (abs_b),
    .quotient  (q),
    .remainder (r),
    .done      (div_done)
  );

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (accept && op_mul)      state_nx = S_MUL;
        else if (accept && op_div) state_nx = S_DIV;
      end
      S_MUL: begin
        if (count == CW'(MUL_CYCLES - 1))
          state_nx = acc_r ? S_ACC : S_IDLE;
      end
      S_ACC:   state_nx = S_IDLE;
      S_DIV:   if (div_done) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      count    <= '0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      acc_r    <= 1'b0;
      sub_r    <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      dvd      <= '0;
    end else begin
      state <= state_nx;
      done  <= 1'b0;
      count <= (state == S_MUL) ? count + 1'b1 : '0;
      if (accept) begin
        if (op == OP_MTHI) hi <= in_1;
        if (op == OP_MTLO) lo <= in_2;
        acc_r    <= op_acc;
        sub_r    <= op_sub;
        neg_q    <= op_sgn & (in_1[WIDTH-1] ^ in_2[WIDTH-1]);
        neg_r    <= op_sgn & in_1[WIDTH-1];
        div_zero <= (in_2 == '0);
        dvd      <= in_1;
      end
      case (state)
        S_MUL: begin
          if (count == CW'(MUL_CYCLES - 1) && !acc_r) begin
            {hi, lo} <= pipe[MUL_CYCLES-1];
            done     <= 1'b1;
          end
        end
        S_ACC: begin
          {hi, lo} <= sub_r ? {hi, lo} - pipe[MUL_CYCLES-1]
                            : {hi, lo} + pipe[MUL_CYCLES-1];
          done     <= 1'b1;
        end
        S_DIV: begin
          if (div_done) begin
            done <= 1'b1;
            if (div_zero) begin
              lo <= DIV_ZERO_LO[WIDTH-1:0];
              hi <= dvd;
            end else begin
              lo <= neg_q ? -q : q;
              hi <= neg_r ? -r : r;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
// Table of single ops plus stall, accumulate and reset-abort sequences.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W  = 32;
  localparam int MC = 3;
  localparam int DC = W + 1;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  muldiv_op_t   op;
  logic [W-1:0] in_1, in_2;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W), .MUL_CYCLES(MC)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .in_1  (in_1),
    .in_2  (in_2),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  typedef struct {
    muldiv_op_t  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
    int          dn;
  } vec_t;

  vec_t vt[$];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Issue one op, count busy cycles and done pulses until idle.
  task automatic run(input muldiv_op_t o, input logic [W-1:0] a,
                     input logic [W-1:0] b, output int cyc, output int dn);
    @(negedge clk);
    start = 1'b1; op = o; in_1 = a; in_2 = b;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    dn  = 0;
    while (busy && cyc < 200) begin
      cyc++;
      if (done) dn++;
      @(negedge clk);
    end
    if (done) dn++;
    @(negedge clk);
    if (done) dn++;
  endtask

  initial begin
    int cyc, dn;
    reset = 1'b1; start = 1'b0; op = OP_MTHI; in_1 = '0; in_2 = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    reset = 1'b0;

    vt.push_back('{OP_MTHI,  32'hDEADBEEF, 32'h0,
                   32'hDEADBEEF, 32'h0, 0, 0});
    vt.push_back('{OP_MTLO,  32'h0, 32'h12345678,
                   32'hDEADBEEF, 32'h12345678, 0, 0});
    vt.push_back('{OP_MULT,  32'hFFFFFFFF, 32'h2,
                   32'hFFFFFFFF, 32'hFFFFFFFE, MC, 1});
    vt.push_back('{OP_MULTU, 32'hFFFFFFFF, 32'h2,
                   32'h1, 32'hFFFFFFFE, MC, 1});
    vt.push_back('{OP_MULT,  32'h80000000, 32'h80000000,
                   32'h40000000, 32'h0, MC, 1});
    vt.push_back('{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,
                   32'hFFFFFFFE, 32'h1, MC, 1});
    vt.push_back('{OP_DIV,   32'hFFFFFFF9, 32'h2,
                   32'hFFFFFFFF, 32'hFFFFFFFD, DC, 1});
    vt.push_back('{OP_DIV,   32'h7, 32'hFFFFFFFE,
                   32'h1, 32'hFFFFFFFD, DC, 1});
    vt.push_back('{OP_DIVU,  32'd100, 32'h0,
                   32'd100, 32'hFFFFFFFF, DC, 1});
    vt.push_back('{OP_DIV,   32'h80000000, 32'hFFFFFFFF,
                   32'h0, 32'h80000000, DC, 1});
    vt.push_back('{OP_DIVU,  32'd100, 32'd7,
                   32'd2, 32'd14, DC, 1});
    vt.push_back('{OP_DIVU,  32'hFFFFFFFF, 32'h1,
                   32'h0, 32'hFFFFFFFF, DC, 1});
    vt.push_back('{OP_DIV,   32'hFFFFFFF8, 32'h0,
                   32'hFFFFFFF8, 32'hFFFFFFFF, DC, 1});
    vt.push_back('{muldiv_op_t'(4'hF), 32'h5, 32'h6,
                   32'hFFFFFFF8, 32'hFFFFFFFF, 0, 0});
    vt.push_back('{OP_MTHI,  32'h0, 32'h0,
                   32'h0, 32'hFFFFFFFF, 0, 0});
    vt.push_back('{OP_MTLO,  32'h0, 32'hFFFFFFFF,
                   32'h0, 32'hFFFFFFFF, 0, 0});
`ifdef MULDIV_MADD_EN
    vt.push_back('{OP_MADDU, 32'h1, 32'h1,
                   32'h1, 32'h0, MC + 1, 1});
    vt.push_back('{OP_MSUB,  32'h1, 32'h2,
                   32'h0, 32'hFFFFFFFE, MC + 1, 1});
`else
    vt.push_back('{OP_MADDU, 32'h1, 32'h1,
                   32'h0, 32'hFFFFFFFF, 0, 0});
    vt.push_back('{OP_MSUB,  32'h1, 32'h2,
                   32'h0, 32'hFFFFFFFF, 0, 0});
`endif

    foreach (vt[i]) begin
      run(vt[i].op, vt[i].a, vt[i].b, cyc, dn);
      check($sformatf("v%0d_hi", i), 64'(hi), 64'(vt[i].hi));
      check($sformatf("v%0d_lo", i), 64'(lo), 64'(vt[i].lo));
      check($sformatf("v%0d_busy_cyc", i), 64'(cyc), 64'(vt[i].cyc));
      check($sformatf("v%0d_done_cnt", i), 64'(dn), 64'(vt[i].dn));
    end

    // MULTU issued mid-DIVU and in its last busy cycle must be dropped.
    @(negedge clk);
    start = 1'b1; op = OP_DIVU; in_1 = 32'd1000; in_2 = 32'd3;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    dn  = 0;
    while (busy && cyc < 200) begin
      cyc++;
      if (done) dn++;
      if (cyc == 5 || cyc == DC) begin
        start = 1'b1; op = OP_MULTU; in_1 = 32'd5; in_2 = 32'd5;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (done) dn++;
    repeat (3) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("stall_busy_cyc", 64'(cyc), 64'(DC));
    check("stall_done_cnt", 64'(dn), 64'd1);
    check("stall_hi", 64'(hi), 64'd1);
    check("stall_lo", 64'(lo), 64'd333);
    check("stall_idle", 64'(busy), 64'd0);

    // Reset in cycle 10 of a DIVU aborts it without a result.
    @(negedge clk);
    start = 1'b1; op = OP_DIVU; in_1 = 32'd1000; in_2 = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("abort_busy_before", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd0);
    dn = 0;
    repeat (40) begin
      if (done) dn++;
      @(negedge clk);
    end
    check("abort_done_cnt", 64'(dn), 64'd0);
    check("abort_hi_late", 64'(hi), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
